// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request; misaligned halves/words become byte beats.
// Latency: aligned 2 cycles, misaligned half 3, misaligned word 5, illegal request 1 (accept to response).
// Backpressure: req_ready_o is low from accept through the response cycle; no back-to-back accepts.
module load_store_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] address_i,
   input  logic [31:0] store_data_i,
   output logic        resp_valid_o,
   output logic [31:0] load_data_o,
   output logic        err_o,
   output logic        misaligned_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_write_data_o,
   output logic        mem_is_load_o,
   output logic        mem_is_store_o,
   output logic [2:0]  mem_funct3_o,
   input  logic [31:0] mem_read_data_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [2:0]  funct3_q;
   logic        is_load_q;
   logic        mis_q;
   logic [2:0]  beat_q;
   logic [2:0]  count_q;
   logic [31:0] buf_q;

   logic [2:0]  req_size;
   logic        req_mis;
   logic        req_illegal;
   logic [31:0] beat_addr;
   logic [31:0] store_shift;
   logic [31:0] buf_nxt;
   logic [31:0] ext_data;
   logic        last_beat;

   // Decode the incoming request: access size, alignment and legality.
   always_comb begin
      req_size = 3'd1;
      case (funct3_i[1:0])
         2'b01:   req_size = 3'd2;
         2'b10:   req_size = 3'd4;
         default: req_size = 3'd1;
      endcase
      req_mis = ((funct3_i[1:0] == 2'b01) && address_i[0]) ||
                ((funct3_i[1:0] == 2'b10) && (address_i[1:0] != 2'b00));
      req_illegal = (is_load_i == is_store_i) ||
                    (is_load_i && ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                                   (funct3_i == 3'b111))) ||
                    (is_store_i && (funct3_i >= 3'b011));
   end

   assign beat_addr   = addr_q + {29'd0, beat_q};
   assign store_shift = data_q >> {beat_q[1:0], 3'b000};
   assign last_beat   = (beat_q == (count_q - 3'd1));

   // Merge this beat's byte into the reassembly buffer and apply load extension.
   always_comb begin
      buf_nxt = buf_q;
      case (beat_q[1:0])
         2'd0: buf_nxt[7:0]   = mem_read_data_i[7:0];
         2'd1: buf_nxt[15:8]  = mem_read_data_i[7:0];
         2'd2: buf_nxt[23:16] = mem_read_data_i[7:0];
         default: buf_nxt[31:24] = mem_read_data_i[7:0];
      endcase
      case (funct3_q)
         3'b001:  ext_data = {{16{buf_nxt[15]}}, buf_nxt[15:0]};
         3'b101:  ext_data = {16'd0, buf_nxt[15:0]};
         default: ext_data = buf_nxt;
      endcase
   end

   // Memory-side drive: only active in ACCESS, strobes killed while reset is asserted.
   always_comb begin
      mem_address_o    = 32'd0;
      mem_write_data_o = 32'd0;
      mem_funct3_o     = 3'd0;
      mem_is_load_o    = 1'b0;
      mem_is_store_o   = 1'b0;
      if (state == ACCESS) begin
         if (mis_q) begin
            mem_address_o    = beat_addr;
            mem_funct3_o     = is_load_q ? 3'b100 : 3'b000;
            mem_write_data_o = {24'd0, store_shift[7:0]};
         end else begin
            mem_address_o    = addr_q;
            mem_funct3_o     = funct3_q;
            mem_write_data_o = data_q;
         end
         mem_is_load_o  = is_load_q & ~rst_i;
         mem_is_store_o = ~is_load_q & ~rst_i;
      end
   end

   assign req_ready_o  = (state == IDLE) & ~rst_i;
   assign resp_valid_o = (state == DONE);

   // Request sequencing: latch, step through beats, publish the response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         addr_q       <= 32'd0;
         data_q       <= 32'd0;
         funct3_q     <= 3'd0;
         is_load_q    <= 1'b0;
         mis_q        <= 1'b0;
         beat_q       <= 3'd0;
         count_q      <= 3'd0;
         buf_q        <= 32'd0;
         load_data_o  <= 32'd0;
         err_o        <= 1'b0;
         misaligned_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  addr_q    <= address_i;
                  data_q    <= store_data_i;
                  funct3_q  <= funct3_i;
                  is_load_q <= is_load_i;
                  mis_q     <= req_mis;
                  count_q   <= req_mis ? req_size : 3'd1;
                  beat_q    <= 3'd0;
                  buf_q     <= 32'd0;
                  if (req_illegal) begin
                     state        <= DONE;
                     err_o        <= 1'b1;
                     misaligned_o <= 1'b0;
                     load_data_o  <= 32'd0;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               beat_q <= beat_q + 3'd1;
               buf_q  <= buf_nxt;
               if (last_beat) begin
                  state        <= DONE;
                  err_o        <= 1'b0;
                  misaligned_o <= mis_q;
                  if (!is_load_q)
                     load_data_o <= 32'd0;
                  else if (mis_q)
                     load_data_o <= ext_data;
                  else
                     load_data_o <= mem_read_data_i;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
